// File: rtl/mm_pkg.sv
// Shared definitions for the mm_stream_nxn matrix-multiply engine: state
// encoding, counter-width helper and operand extension.
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    OUT    = 3'd4
  } state_t;

  // Bits needed to index 'value' entries; never returns less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // Sign- or zero-extends the low 'width' bits of data to 128 bits.
  function automatic logic [127:0] ext(input logic [63:0] data, input int width,
                                       input bit is_signed);
    logic [127:0] mask;
    logic [127:0] result;
    logic         sign;
    mask   = ~(128'd0) << width;
    sign   = is_signed && (((data >> (width - 1)) & 64'd1) != 64'd0);
    result = {64'd0, data} & ~mask;
    if (sign) result = result | mask;
    return result;
  endfunction

endpackage

// File: rtl/mm_mac_lane.sv
// One multiply-accumulate lane: one column of the output row being built.
module mm_mac_lane
  import mm_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pACC_WIDTH  = 32,
  parameter int pSIGNED     = 0
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   clear,
  input  logic                   en,
  input  logic [pDATA_WIDTH-1:0] a,
  input  logic [pDATA_WIDTH-1:0] b,
  output logic [pACC_WIDTH-1:0]  acc_next,
  output logic [pACC_WIDTH-1:0]  acc
);

  logic [127:0] a_ext;
  logic [127:0] b_ext;
  logic [127:0] product;

  // Low bits of the wide product equal the 2W product truncated to the accumulator.
  always_comb begin
    a_ext    = ext(64'(a), pDATA_WIDTH, pSIGNED != 0);
    b_ext    = ext(64'(b), pDATA_WIDTH, pSIGNED != 0);
    product  = a_ext * b_ext;
    acc_next = acc + pACC_WIDTH'(product);
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst)   acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= acc_next;
  end

endmodule

// File: rtl/mm_stream_nxn.sv
// AXI-Stream N x N matrix multiply: A then B in, C = A*B out row-major.
// Define MM_SAT_EN to saturate C into the output width and add sat_flag.
module mm_stream_nxn
  import mm_pkg::*;
#(
  parameter int pN          = 4,
  parameter int pDATA_WIDTH = 32,
  parameter int pACC_WIDTH  = 32,
  parameter int pSIGNED     = 0
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  output logic                   busy,
  output logic                   err_tlast
`ifdef MM_SAT_EN
  ,
  output logic                   sat_flag
`endif
);

  localparam int NN = pN * pN;
  localparam int IW = clog2(NN);
  localparam int RW = clog2(pN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
  localparam logic [IW-1:0] ONE_I    = IW'(1);
  localparam logic [RW-1:0] LAST_RK  = RW'(pN - 1);
  localparam logic [RW-1:0] ONE_R    = RW'(1);

  state_t state, next_state;
  logic [IW-1:0] in_cnt, out_cnt, load_idx;
  logic [RW-1:0] r, k;
  logic [pDATA_WIDTH-1:0] a_buf [NN];
  logic [pDATA_WIDTH-1:0] b_buf [NN];
  logic [pACC_WIDTH-1:0]  c_buf [NN];
  logic [pDATA_WIDTH-1:0] a_op;
  logic [pDATA_WIDTH-1:0] b_lane [pN];
  logic [pACC_WIDTH-1:0]  lane_next [pN];
  logic [pACC_WIDTH-1:0]  lane_acc_unused [pN];
  logic [pACC_WIDTH-1:0]  load_c;
  logic [pDATA_WIDTH-1:0] load_data;
  logic in_hs, out_hs, row_end, calc_done, in_last, load_beat;
`ifdef MM_SAT_EN
  logic load_clip;
  logic signed [pACC_WIDTH-1:0] load_hi;
`endif

  assign in_hs     = ss_tvalid & ss_tready;
  assign out_hs    = sm_tvalid & sm_tready;
  assign in_last   = (in_cnt == LAST_IDX);
  assign row_end   = (k == LAST_RK);
  assign calc_done = row_end && (r == LAST_RK);
  assign a_op      = a_buf[IW'(int'(r) * pN + int'(k))];
  // A beat is loaded into the output register on entering OUT and after each non-final handshake.
  assign load_beat = (state == OUT) && (!sm_tvalid || (sm_tready && !sm_tlast));
  assign load_idx  = sm_tvalid ? out_cnt + ONE_I : out_cnt;

  for (genvar j = 0; j < pN; j++) begin : g_lane
    assign b_lane[j] = b_buf[IW'(int'(k) * pN + j)];
    mm_mac_lane #(
      .pDATA_WIDTH(pDATA_WIDTH),
      .pACC_WIDTH (pACC_WIDTH),
      .pSIGNED    (pSIGNED)
    ) u_lane (
      .axis_clk(axis_clk),
      .axis_rst(axis_rst),
      .clear   ((state == CALC) && row_end),
      .en      (state == CALC),
      .a       (a_op),
      .b       (b_lane[j]),
      .acc_next(lane_next[j]),
      .acc     (lane_acc_unused[j])
    );
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_hs) next_state = LOAD_A;
      LOAD_A:  if (in_hs && in_last) next_state = LOAD_B;
      LOAD_B:  if (in_hs && in_last) next_state = CALC;
      CALC:    if (calc_done) next_state = OUT;
      OUT:     if (out_hs && sm_tlast) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    ss_tready = !axis_rst && (state == IDLE || state == LOAD_A || state == LOAD_B);
  end

  // Narrowing of a stored C element into the stream width.
  always_comb begin
    load_c    = c_buf[load_idx];
    load_data = pDATA_WIDTH'(load_c);
`ifdef MM_SAT_EN
    load_clip = 1'b0;
    load_hi   = $signed(load_c) >>> (pDATA_WIDTH - 1);
    if (pSIGNED != 0) begin
      if (load_hi != '0 && load_hi != '1) begin
        load_clip = 1'b1;
        load_data = load_c[pACC_WIDTH-1] ? {1'b1, {(pDATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(pDATA_WIDTH-1){1'b1}}};
      end
    end else if ((load_c >> pDATA_WIDTH) != '0) begin
      load_clip = 1'b1;
      load_data = '1;
    end
`endif
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      r         <= '0;
      k         <= '0;
      err_tlast <= 1'b0;
      sm_tvalid <= 1'b0;
      sm_tdata  <= '0;
      sm_tlast  <= 1'b0;
      for (int i = 0; i < NN; i++) begin
        a_buf[i] <= '0;
        b_buf[i] <= '0;
        c_buf[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (in_hs) begin
          a_buf[0]  <= ss_tdata;
          in_cnt    <= ONE_I;
          err_tlast <= ss_tlast;
        end
        LOAD_A: if (in_hs) begin
          a_buf[in_cnt] <= ss_tdata;
          if (ss_tlast) err_tlast <= 1'b1;
          in_cnt <= in_last ? '0 : in_cnt + ONE_I;
        end
        LOAD_B: if (in_hs) begin
          b_buf[in_cnt] <= ss_tdata;
          if (ss_tlast != in_last) err_tlast <= 1'b1;
          in_cnt <= in_last ? '0 : in_cnt + ONE_I;
        end
        CALC: begin
          if (row_end) begin
            for (int j = 0; j < pN; j++) c_buf[IW'(int'(r) * pN + j)] <= lane_next[j];
            r <= calc_done ? '0 : r + ONE_R;
          end
          k <= row_end ? '0 : k + ONE_R;
        end
        OUT: begin
          if (load_beat) begin
            sm_tvalid <= 1'b1;
            sm_tdata  <= load_data;
            sm_tlast  <= (load_idx == LAST_IDX);
            out_cnt   <= load_idx;
          end else if (out_hs) begin
            sm_tvalid <= 1'b0;
            sm_tdata  <= '0;
            sm_tlast  <= 1'b0;
            out_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MM_SAT_EN
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst)                        sat_flag <= 1'b0;
    else if (state == IDLE && in_hs)     sat_flag <= 1'b0;
    else if (load_beat && load_clip)     sat_flag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mm_stream_nxn.sv
// Bench for mm_stream_nxn: three 4x4 instances (unsigned 32, signed 32,
// unsigned 8-bit/24-bit acc) fed in lockstep and checked against a matrix model.
module tb_mm_stream_nxn;

  localparam int N  = 4;
  localparam int NN = 16;
  localparam int CFG_W[3]   = '{32, 32, 8};
  localparam int CFG_ACC[3] = '{32, 32, 24};
  localparam bit CFG_SGN[3] = '{1'b0, 1'b1, 1'b0};
`ifdef MM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        axis_clk = 1'b0;
  logic        axis_rst;
  logic        ss_tvalid, ss_tlast, sm_tready;
  logic [31:0] ss_tdata;
  logic        ss_tready_v [3];
  logic        sm_tvalid_v [3];
  logic        sm_tlast_v  [3];
  logic        busy_v      [3];
  logic        err_v       [3];
  logic [31:0] sm_tdata0, sm_tdata1;
  logic [7:0]  sm_tdata2;
  logic [31:0] obs_data    [3];
`ifdef MM_SAT_EN
  logic        sat_v       [3];
`endif

  logic [31:0] a_mat [NN];
  logic [31:0] b_mat [NN];
  logic [31:0] expected [3][NN];
  bit          exp_sat  [3];
  int          checks   = 0;
  int          failures = 0;

  assign obs_data[0] = sm_tdata0;
  assign obs_data[1] = sm_tdata1;
  assign obs_data[2] = {24'd0, sm_tdata2};

  always #5 axis_clk = ~axis_clk;

  mm_stream_nxn #(.pN(N), .pDATA_WIDTH(32), .pACC_WIDTH(32), .pSIGNED(0)) u_dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst), .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata),
    .ss_tlast(ss_tlast), .ss_tready(ss_tready_v[0]), .sm_tvalid(sm_tvalid_v[0]),
    .sm_tdata(sm_tdata0), .sm_tlast(sm_tlast_v[0]), .sm_tready(sm_tready),
    .busy(busy_v[0]), .err_tlast(err_v[0])
`ifdef MM_SAT_EN
    , .sat_flag(sat_v[0])
`endif
  );

  mm_stream_nxn #(.pN(N), .pDATA_WIDTH(32), .pACC_WIDTH(32), .pSIGNED(1)) u_sgn (
    .axis_clk(axis_clk), .axis_rst(axis_rst), .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata),
    .ss_tlast(ss_tlast), .ss_tready(ss_tready_v[1]), .sm_tvalid(sm_tvalid_v[1]),
    .sm_tdata(sm_tdata1), .sm_tlast(sm_tlast_v[1]), .sm_tready(sm_tready),
    .busy(busy_v[1]), .err_tlast(err_v[1])
`ifdef MM_SAT_EN
    , .sat_flag(sat_v[1])
`endif
  );

  mm_stream_nxn #(.pN(N), .pDATA_WIDTH(8), .pACC_WIDTH(24), .pSIGNED(0)) u_small (
    .axis_clk(axis_clk), .axis_rst(axis_rst), .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata[7:0]),
    .ss_tlast(ss_tlast), .ss_tready(ss_tready_v[2]), .sm_tvalid(sm_tvalid_v[2]),
    .sm_tdata(sm_tdata2), .sm_tlast(sm_tlast_v[2]), .sm_tready(sm_tready),
    .busy(busy_v[2]), .err_tlast(err_v[2])
`ifdef MM_SAT_EN
    , .sat_flag(sat_v[2])
`endif
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint ext_val(input logic [31:0] v, input int w, input bit sgn);
    longint x;
    x = longint'(v) & ((longint'(1) << w) - 1);
    if (sgn && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
    return x;
  endfunction

  // C[r][j] = sum_k A[r][k]*B[k][j], reduced mod 2^acc, then truncated or clipped to w.
  function automatic logic [31:0] model_elem(input int idx, input int cfg, output bit clipped);
    int     w, accw, row, col;
    bit     sgn;
    longint sum, c, wm, half;
    w = CFG_W[cfg]; accw = CFG_ACC[cfg]; sgn = CFG_SGN[cfg];
    row = idx / N; col = idx % N;
    sum = 0;
    for (int kk = 0; kk < N; kk++)
      sum += ext_val(a_mat[row*N + kk], w, sgn) * ext_val(b_mat[kk*N + col], w, sgn);
    c    = sum & ((longint'(1) << accw) - 1);
    wm   = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    clipped = 1'b0;
    if (SAT) begin
      if (sgn) begin
        if (c >= (longint'(1) << (accw - 1))) c = c - (longint'(1) << accw);
        if (c > half - 1) begin c = half - 1; clipped = 1'b1; end
        else if (c < -half) begin c = -half; clipped = 1'b1; end
      end else if (c > wm) begin
        c = wm; clipped = 1'b1;
      end
    end
    return 32'(c & wm);
  endfunction

  task automatic compute_expected();
    bit clip;
    for (int d = 0; d < 3; d++) begin
      exp_sat[d] = 1'b0;
      for (int i = 0; i < NN; i++) begin
        expected[d][i] = model_elem(i, d, clip);
        if (clip) exp_sat[d] = 1'b1;
      end
    end
  endtask

  // Streams A then B with random input gaps; err_frame moves tlast to beat 10.
  task automatic apply_stimulus(input bit err_frame);
    compute_expected();
    for (int beat = 0; beat < 2*NN; beat++) begin
      @(negedge axis_clk);
      while ($urandom_range(0, 4) == 0) begin
        ss_tvalid = 1'b0;
        @(negedge axis_clk);
      end
      ss_tvalid = 1'b1;
      ss_tdata  = (beat < NN) ? a_mat[beat] : b_mat[beat - NN];
      ss_tlast  = err_frame ? (beat == 9) : (beat == 2*NN - 1);
      if (beat == 0 || beat == 2*NN - 1)
        for (int d = 0; d < 3; d++) check_output("ss_tready_load", ss_tready_v[d], 1);
      @(posedge axis_clk);
      #1;
      if (beat == 0)
        for (int d = 0; d < 3; d++) check_output("err_clear_first_beat", err_v[d], 0);
      if (err_frame && beat == 9)
        for (int d = 0; d < 3; d++) check_output("err_set_beat10", err_v[d], 1);
    end
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
  endtask

  // ready_mode: 0 always ready, 1 toggling, 2 random.
  task automatic collect_output(input int ready_mode, input bit err_exp);
    int          edges, got, cyc;
    bit          prev_stall;
    logic [31:0] prev_data [3];
    logic        prev_last;
    edges = 0;
    while (edges < 100 && sm_tvalid_v[0] !== 1'b1) begin
      @(posedge axis_clk);
      #1;
      edges++;
    end
    check_output("latency", edges, 17);
    check_output("valid_sgn", sm_tvalid_v[1], 1);
    check_output("valid_small", sm_tvalid_v[2], 1);
    got = 0; cyc = 0; prev_stall = 1'b0; prev_last = 1'b0;
    while (got < NN && cyc < 400) begin
      @(negedge axis_clk);
      if (prev_stall) begin
        for (int d = 0; d < 3; d++) check_output("stall_stable_data", obs_data[d], prev_data[d]);
        check_output("stall_stable_last", sm_tlast_v[0], prev_last);
      end
      case (ready_mode)
        0:       sm_tready = 1'b1;
        1:       sm_tready = (cyc % 2 == 0);
        default: sm_tready = ($urandom_range(0, 2) != 0);
      endcase
      prev_stall = 1'b0;
      if (sm_tvalid_v[0] === 1'b1) begin
        if (sm_tready) begin
          for (int d = 0; d < 3; d++) check_output("c_data", obs_data[d], expected[d][got]);
          check_output("tlast", sm_tlast_v[0], (got == NN - 1));
          got++;
        end else begin
          prev_stall = 1'b1;
          for (int d = 0; d < 3; d++) prev_data[d] = obs_data[d];
          prev_last = sm_tlast_v[0];
        end
      end
      cyc++;
    end
    check_output("out_beat_count", got, NN);
    @(posedge axis_clk);
    #1;
    sm_tready = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check_output("idle_valid", sm_tvalid_v[d], 0);
      check_output("idle_busy", busy_v[d], 0);
      check_output("idle_ready", ss_tready_v[d], 1);
      check_output("err_tlast", err_v[d], err_exp);
`ifdef MM_SAT_EN
      check_output("sat_flag", sat_v[d], exp_sat[d]);
`endif
    end
  endtask

  task automatic fill(input logic [31:0] a_val, input logic [31:0] b_val);
    for (int i = 0; i < NN; i++) begin
      a_mat[i] = a_val;
      b_mat[i] = b_val;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NN; i++) begin
      a_mat[i] = $urandom;
      b_mat[i] = $urandom;
    end
  endtask

  initial begin
    int highs;
    axis_rst = 1'b1; ss_tvalid = 1'b0; ss_tlast = 1'b0; ss_tdata = '0; sm_tready = 1'b0;
    repeat (2) @(negedge axis_clk);
    for (int d = 0; d < 3; d++) begin
      check_output("rst_ss_tready", ss_tready_v[d], 0);
      check_output("rst_sm_tvalid", sm_tvalid_v[d], 0);
      check_output("rst_sm_tlast", sm_tlast_v[d], 0);
      check_output("rst_sm_tdata", obs_data[d], 0);
      check_output("rst_busy", busy_v[d], 0);
      check_output("rst_err", err_v[d], 0);
    end
    axis_rst = 1'b0;
    #1;
    check_output("post_rst_ready", ss_tready_v[0], 1);

    $display("[TB] identity x sequence");
    for (int i = 0; i < NN; i++) begin
      a_mat[i] = (i / N == i % N) ? 32'd1 : 32'd0;
      b_mat[i] = 32'(i + 1);
    end
    apply_stimulus(1'b0);
    collect_output(0, 1'b0);

    $display("[TB] all 2 x all 3, toggling ready");
    fill(32'd2, 32'd3);
    apply_stimulus(1'b0);
    collect_output(1, 1'b0);

    $display("[TB] all -1 x all 1");
    fill(32'hFFFF_FFFF, 32'd1);
    apply_stimulus(1'b0);
    collect_output(0, 1'b0);

    $display("[TB] random data, misplaced tlast");
    fill_random();
    apply_stimulus(1'b1);
    collect_output(2, 1'b1);

    $display("[TB] all 100 x all 100");
    fill(32'd100, 32'd100);
    apply_stimulus(1'b0);
    collect_output(2, 1'b0);

    $display("[TB] reset during CALC");
    fill_random();
    apply_stimulus(1'b0);
    repeat (5) @(posedge axis_clk);
    @(negedge axis_clk);
    axis_rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_output("midrst_valid", sm_tvalid_v[d], 0);
      check_output("midrst_data", obs_data[d], 0);
      check_output("midrst_busy", busy_v[d], 0);
    end
    @(negedge axis_clk);
    axis_rst = 1'b0;
    #1;
    check_output("midrst_ready", ss_tready_v[0], 1);
    highs = 0;
    repeat (30) begin
      @(negedge axis_clk);
      if (sm_tvalid_v[0] !== 1'b0) highs++;
    end
    check_output("midrst_no_output", highs, 0);

    $display("[TB] random frame after reset");
    fill_random();
    apply_stimulus(1'b0);
    collect_output(2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
